// File: rtl/top_pkg.sv
// Shared definitions for the stepping micro-sequencer: ISA encoding,
// default program image, hex display font and display source codes.
package top_pkg;
  localparam int CNT_W      = 26;
  localparam int PC_W       = 5;
  localparam int ROM_DEPTH  = 32;
  localparam int INSTR_W    = 10;
  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_DJNZ = 2'd1,
    OP_JMP  = 2'd2,
    OP_HALT = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] imm;
  } instr_t;

  typedef logic [ROM_DEPTH-1:0][INSTR_W-1:0] rom_t;

  typedef enum logic [2:0] {
    SHOW_LED    = 3'd0,
    SHOW_ALL    = 3'd1,
    SHOW_BRANCH = 3'd2,
    SHOW_JMP    = 3'd3,
    SHOW_PC     = 3'd4,
    SHOW_ACC    = 3'd5,
    SHOW_HALTED = 3'd6,
    SHOW_ZERO   = 3'd7
  } show_e;

  // IDLE is the post-reset halt (resume in place); HALT follows a HALT
  // instruction (resume at the next address).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } run_state_e;

  // Entry 0 is the rightmost element: ADD 5; JMP 3; ADD 0xFF; DJNZ 3; HALT...
  localparam rom_t DEFAULT_ROM = {{28{10'h300}}, 10'h103, 10'h0FF, 10'h203, 10'h005};

  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    return HEX_FONT[nib];
  endfunction

  function automatic logic [CNT_W-1:0] rate_mask(input logic [1:0] hz);
    case (hz)
      2'd0:    return CNT_W'(26'h0000000);
      2'd1:    return CNT_W'(26'h000000F);
      2'd2:    return CNT_W'(26'h000FFFF);
      default: return CNT_W'(26'h0FFFFFF);
    endcase
  endfunction
endpackage

// File: rtl/top_seg_scan.sv
// Multiplexed 8-digit seven-segment driver: one nibble per scan slot,
// registered active-low segments and digit enables.
module seg_scan import top_pkg::*; (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] word,
  input  logic [2:0]  idx,
  output logic [7:0]  seg,
  output logic [7:0]  an
);
  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0]      an_n;
  logic [2:0]                 sel;

  assign nib = word;
  // Reset parks the scan on digit 0 so the display is defined immediately.
  assign sel = clr ? idx : 3'd0;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an
    assign an_n[i] = (sel != 3'(i));
  end

  always_ff @(posedge clk) begin
    seg <= hex_seg(nib[sel]);
    an  <= an_n;
  end
endmodule

// File: rtl/top.sv
// Stepping micro-sequencer: 32-entry ROM, rate-divided step clock,
// Go-driven halt/resume, statistics counters and a scanned hex display.
module top import top_pkg::*; #(
  parameter int   SCAN_SH  = 16,
  parameter rom_t ROM_INIT = DEFAULT_ROM
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       Go,
  input  logic [2:0] Show,
  input  logic [1:0] Hz,
  output logic       clk_N,
  output logic [7:0] SEG,
  output logic [7:0] AN
);
  logic [CNT_W-1:0] cnt;
  logic             tick, step, go_q, go_rise;

  run_state_e       state, state_n;
  logic [PC_W-1:0]  pc, pc_n;
  logic [7:0]       acc, acc_n, acc_dec;
  logic [31:0]      leddata, leddata_n;
  logic [31:0]      cnt_all, cnt_all_n;
  logic [31:0]      cnt_br, cnt_br_n;
  logic [31:0]      cnt_jmp, cnt_jmp_n;
  instr_t           instr;
  logic             halted;
  logic [31:0]      word;

  // A tick fires when every bit selected by the rate mask is set.
  assign tick    = &(cnt | ~rate_mask(Hz));
  assign step    = tick & ~clk_N;
  assign go_rise = Go & ~go_q;
  assign halted  = (state != ST_RUN);
  assign instr   = instr_t'(ROM_INIT[pc]);
  assign acc_dec = acc - 8'd1;

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt     <= '0;
      clk_N   <= 1'b0;
      go_q    <= 1'b0;
      state   <= ST_IDLE;
      pc      <= '0;
      acc     <= '0;
      leddata <= '0;
      cnt_all <= '0;
      cnt_br  <= '0;
      cnt_jmp <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
      if (tick) clk_N <= ~clk_N;
      go_q    <= Go;
      state   <= state_n;
      pc      <= pc_n;
      acc     <= acc_n;
      leddata <= leddata_n;
      cnt_all <= cnt_all_n;
      cnt_br  <= cnt_br_n;
      cnt_jmp <= cnt_jmp_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    acc_n     = acc;
    leddata_n = leddata;
    cnt_all_n = cnt_all;
    cnt_br_n  = cnt_br;
    cnt_jmp_n = cnt_jmp;
    // Resume takes priority; a step landing on the same clk is dropped.
    if (go_rise && halted) begin
      state_n = ST_RUN;
      if (state == ST_HALT) pc_n = pc + 5'd1;
    end else if (step && !halted) begin
      cnt_all_n = cnt_all + 32'd1;
      case (instr.op)
        OP_ADD: begin
          acc_n = acc + instr.imm;
          pc_n  = pc + 5'd1;
        end
        OP_DJNZ: begin
          acc_n = acc_dec;
          if (acc_dec != 8'd0) begin
            pc_n     = instr.imm[PC_W-1:0];
            cnt_br_n = cnt_br + 32'd1;
          end else begin
            pc_n = pc + 5'd1;
          end
        end
        OP_JMP: begin
          pc_n      = instr.imm[PC_W-1:0];
          cnt_jmp_n = cnt_jmp + 32'd1;
        end
        OP_HALT: begin
          leddata_n = {11'b0, pc, 8'h00, acc};
          state_n   = ST_HALT;
        end
      endcase
    end
  end

  always_comb begin
    word = '0;
    case (Show)
      SHOW_LED:    word = leddata;
      SHOW_ALL:    word = cnt_all;
      SHOW_BRANCH: word = cnt_br;
      SHOW_JMP:    word = cnt_jmp;
      SHOW_PC:     word = {27'b0, pc};
      SHOW_ACC:    word = {24'b0, acc};
      SHOW_HALTED: word = {31'b0, halted};
      default:     word = '0;
    endcase
  end

  seg_scan u_scan (
    .clk  (clk),
    .clr  (clr),
    .word (word),
    .idx  (cnt[SCAN_SH+2:SCAN_SH]),
    .seg  (SEG),
    .an   (AN)
  );
endmodule

// File: tb/tb_top.sv
// Bench for top: two instances (default program at Hz=0, custom program at
// Hz=1), state read back by decoding the scanned display against a scoreboard.
module tb_top;
  localparam logic [2:0] S_LED = 3'd0, S_ALL = 3'd1, S_BR = 3'd2, S_JMP = 3'd3,
                         S_PC = 3'd4, S_ACC = 3'd5, S_HALT = 3'd6;
  // 0 ADD 3; 1 DJNZ 1; 2 JMP 31; 31 HALT.
  localparam logic [31:0][9:0] ROM2 = {10'h300, {28{10'h000}}, 10'h21F, 10'h101, 10'h003};
  localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [2:0]  show;
    logic [31:0] word;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] clr = 2'b00;
  logic [1:0] go  = 2'b00;
  logic [2:0] show [2];
  logic [1:0] hz [2];
  logic [1:0] clk_n;
  logic [7:0] seg [2];
  logic [7:0] an [2];
  int         runcyc [2];
  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q [$];

  always #5 clk = ~clk;

  top #(.SCAN_SH(0)) dut0 (
    .clk(clk), .clr(clr[0]), .Go(go[0]), .Show(show[0]), .Hz(hz[0]),
    .clk_N(clk_n[0]), .SEG(seg[0]), .AN(an[0])
  );

  top #(.SCAN_SH(0), .ROM_INIT(ROM2)) dut1 (
    .clk(clk), .clr(clr[1]), .Go(go[1]), .Show(show[1]), .Hz(hz[1]),
    .clk_N(clk_n[1]), .SEG(seg[1]), .AN(an[1])
  );

  // Clks since reset release; the scan digit follows the free counter.
  always @(posedge clk) begin
    runcyc[0] <= clr[0] ? runcyc[0] + 1 : 0;
    runcyc[1] <= clr[1] ? runcyc[1] + 1 : 0;
  end

  function automatic int exp_dig(input int d);
    return (runcyc[d] == 0) ? 0 : (runcyc[d] - 1) % 8;
  endfunction

  function automatic int decode(input logic [7:0] s);
    for (int i = 0; i < 16; i++) if (FONT[i] === s) return i;
    return -1;
  endfunction

  task automatic expect_word(input logic [2:0] s, input logic [31:0] w, input string nm);
    exp_t e;
    e.show = s; e.word = w; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Collects one full scan of the display into a word.
  task automatic read_word(input int d, input logic [2:0] sel, output logic [31:0] w, output bit ok);
    int dig, n;
    w = '0; ok = 1'b1;
    show[d] = sel;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dig = exp_dig(d);
      n = decode(seg[d]);
      if (an[d] !== ~(8'h01 << dig) || n < 0) ok = 1'b0;
      else w[dig*4 +: 4] = 4'(n);
    end
  endtask

  task automatic wait_rise(output bit ok, output int cyc);
    logic prev;
    ok = 1'b0; cyc = 0; prev = clk_n[1];
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      if (clk_n[1] === 1'b1 && prev === 1'b0) begin ok = 1'b1; return; end
      prev = clk_n[1];
    end
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] w; bit ok;
    clr = 2'b00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (an[d] !== 8'hFE) begin failures++; $display("FAIL reset_an%0d: got %h want fe", d, an[d]); end
      checks++;
      if (seg[d] !== 8'hC0) begin failures++; $display("FAIL reset_seg%0d: got %h want c0", d, seg[d]); end
    end
    clr = 2'b11;
    repeat (40) @(negedge clk);
    expect_word(S_ALL, 32'd0, "idle_countAll");
    expect_word(S_HALT, 32'd1, "idle_halted");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(0, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
  endtask

  task automatic test_run();
    exp_t e; logic [31:0] w; bit ok;
    // Second rising edge arrives while the program is still running.
    go[0] = 1'b1; repeat (2) @(negedge clk);
    go[0] = 1'b0; repeat (2) @(negedge clk);
    go[0] = 1'b1; repeat (2) @(negedge clk);
    go[0] = 1'b0; repeat (60) @(negedge clk);
    expect_word(S_ALL,  32'd8,         "run_countAll");
    expect_word(S_BR,   32'd4,         "run_branch");
    expect_word(S_JMP,  32'd1,         "run_jmp");
    expect_word(S_LED,  32'h0004_0000, "run_leddata");
    expect_word(S_PC,   32'd4,         "run_pc");
    expect_word(S_ACC,  32'd0,         "run_acc");
    expect_word(S_HALT, 32'd1,         "run_halted");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(0, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
  endtask

  task automatic test_display();
    int dig; logic [7:0] exp_an, exp_seg;
    show[0] = S_ALL;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dig = exp_dig(0);
      exp_an  = ~(8'h01 << dig);
      exp_seg = (dig == 0) ? 8'h80 : 8'hC0;
      checks++;
      if ({an[0], seg[0]} !== {exp_an, exp_seg}) begin
        failures++;
        $display("FAIL scan_digit%0d: got an=%h seg=%h want an=%h seg=%h", dig, an[0], seg[0], exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_resume();
    exp_t e; logic [31:0] w; bit ok;
    go[0] = 1'b1; repeat (2) @(negedge clk);
    go[0] = 1'b0; repeat (30) @(negedge clk);
    expect_word(S_ALL,  32'd9,         "resume_countAll");
    expect_word(S_LED,  32'h0005_0000, "resume_leddata");
    expect_word(S_PC,   32'd5,         "resume_pc");
    expect_word(S_HALT, 32'd1,         "resume_halted");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(0, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
  endtask

  task automatic test_rate();
    exp_t e; logic [31:0] w; bit ok, seen; int cyc, rises; logic prev;
    show[1] = S_HALT;
    wait_rise(ok, cyc);
    wait_rise(ok, cyc);
    checks++;
    if (!ok || cyc != 32) begin failures++; $display("FAIL clkN_period: got %0d clk (seen=%0d) want 32", cyc, ok); end
    // Just past a rising edge of clk_N, so the Go edge cannot coincide with a step.
    go[1] = 1'b1;
    prev = clk_n[1]; rises = 0; seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 1) go[1] = 1'b0;
      if (clk_n[1] === 1'b1 && prev === 1'b0) rises++;
      prev = clk_n[1];
      if (k > 3 && an[1] === 8'hFE && seg[1] === 8'hF9) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || rises != 6) begin failures++; $display("FAIL steps_per_edge: got %0d rises (halt seen=%0d) want 6", rises, seen); end
    expect_word(S_ALL, 32'd6,         "rom2_countAll");
    expect_word(S_BR,  32'd2,         "rom2_branch");
    expect_word(S_JMP, 32'd1,         "rom2_jmp");
    expect_word(S_LED, 32'h001F_0000, "rom2_leddata");
    expect_word(S_PC,  32'd31,        "rom2_pc");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(1, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
  endtask

  task automatic test_wrap_clr();
    exp_t e; logic [31:0] w; bit ok; int cyc;
    wait_rise(ok, cyc);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_align: got no clk_N edge want edge"); end
    go[1] = 1'b1; repeat (2) @(negedge clk);
    go[1] = 1'b0;
    expect_word(S_PC,   32'd0, "wrap_pc");
    expect_word(S_HALT, 32'd0, "wrap_running");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(1, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
    // Two steps (ADD 3, DJNZ) put the machine inside the loop.
    wait_rise(ok, cyc);
    wait_rise(ok, cyc);
    expect_word(S_ACC, 32'd2, "loop_acc");
    expect_word(S_ALL, 32'd8, "loop_countAll");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(1, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
    clr[1] = 1'b0; repeat (3) @(negedge clk);
    clr[1] = 1'b1;
    expect_word(S_LED,  32'd0, "clr_leddata");
    expect_word(S_ALL,  32'd0, "clr_countAll");
    expect_word(S_BR,   32'd0, "clr_branch");
    expect_word(S_JMP,  32'd0, "clr_jmp");
    expect_word(S_PC,   32'd0, "clr_pc");
    expect_word(S_ACC,  32'd0, "clr_acc");
    expect_word(S_HALT, 32'd1, "clr_halted");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(1, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
    repeat (100) @(negedge clk);
    expect_word(S_ALL, 32'd0, "postclr_countAll");
    expect_word(S_PC,  32'd0, "postclr_pc");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(1, e.show, w, ok);
      checks++;
      if (!ok || w !== e.word) begin failures++; $display("FAIL %s: got %h (scan ok=%0d) want %h", e.name, w, ok, e.word); end
    end
  endtask

  initial begin
    show[0] = S_LED; show[1] = S_LED;
    hz[0] = 2'd0; hz[1] = 2'd1;
    runcyc[0] = 0; runcyc[1] = 0;
    test_reset();
    test_run();
    test_display();
    test_resume();
    test_rate();
    test_wrap_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter SCAN_SH, default 16, log2 of clk cycles each display digit stays lit.
REQ-002 Parameter ROM_INIT, default the package program (REQ-012), a 32 x 10-bit instruction ROM image.
REQ-003 clk  input  1  system clock; all logic on the rising edge; one clock domain.
REQ-004 clr  input  1  reset, synchronous, active-low.
REQ-005 Go  input  1  run/resume request, rising-edge detected.
REQ-006 Show  input  3  display source select.
REQ-007 Hz  input  2  step-rate select.
REQ-008 clk_N  output  1  divided step clock, registered.
REQ-009 SEG  output  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1.
REQ-010 AN  output  8  active-low one-hot digit enables.

Function
REQ-011 Rate: free-running 26-bit counter; tick when low N bits are all ones, N = 0/4/16/24 for Hz = 0/1/2/3; clk_N toggles on each tick; a step occurs on a tick where clk_N goes 0->1 (Hz=0: step every 2nd clk).
REQ-012 Instruction {op[1:0], imm[7:0]}: op0 ADD acc<=acc+imm, pc+1; op1 DJNZ acc<=acc-1, if result!=0 pc<=imm[4:0] (taken) else pc+1; op2 JMP pc<=imm[4:0]; op3 HALT.
REQ-013 Default program: 0 ADD 5; 1 JMP 3; 2 ADD 0xFF; 3 DJNZ 3; 4..31 HALT.
REQ-014 State: pc 5 bits, acc 8 bits (mod-256 wrap), halted flag, Leddata/countAll/Count_branch/countJmp 32 bits each (wrap).
REQ-015 Each step while not halted executes one instruction; countAll +1 per executed instruction including HALT; Count_branch +1 per taken DJNZ; countJmp +1 per JMP.
REQ-016 HALT: Leddata <= {11'b0, pc, 8'h00, acc}; halted <= 1; pc unchanged.
REQ-017 Go rising edge while halted: halted <= 0, pc <= pc+1 (31 wraps to 0); while running, Go is ignored.
REQ-018 Go edge and a step in the same clk: the step is skipped; execution resumes on the next step.
REQ-019 Display word by Show: 0 Leddata, 1 countAll, 2 Count_branch, 3 countJmp, 4 {27'b0,pc}, 5 {24'b0,acc}, 6 {31'b0,halted}, 7 32'h0.
REQ-020 Scan: digit index = free counter bits [SCAN_SH+2:SCAN_SH]; digit i shows nibble [4i+3:4i] on AN[i]=0; SEG and AN registered, one clk latency.
REQ-021 Hex font (SEG): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.

Reset
REQ-022 clr=0 at a clk edge: counters, pc, acc, Leddata, statistics, clk_N and the Go edge register <= 0; halted <= 1.
REQ-023 After reset: AN = 8'hFE; SEG = font of the selected digit-0 nibble (C0 for Show=0).
REQ-024 clr low mid-run aborts immediately; nothing executes until a Go edge after release.

Structure
REQ-025 Shared package: opcode constants, default ROM image, hex font table, Show codes.
REQ-026 One sub-module seg_scan (word, scan index -> SEG, AN); everything else in top.

Verification
REQ-027 Reset, Show=0, SCAN_SH=0: AN=FE, SEG=C0; countAll stays 0 without Go.
REQ-028 Hz=0, Go pulse: halts at pc=4; countAll=8, Count_branch=4, countJmp=1, Leddata=0x00040000.
REQ-029 Second Go: executes HALT at pc 5; countAll=9, Leddata=0x00050000; Go while running changes nothing.
REQ-030 Show=1, SCAN_SH=0 after REQ-028: digit 0 SEG=80 ("8") with AN=FE, digits 1-7 SEG=C0 in turn.
REQ-031 Hz=1: clk_N period 32 clk; exactly one step per clk_N rising edge.
REQ-032 Custom ROM_INIT with HALT at 31: Go resumes at pc=0 (wrap); clr pulse mid-loop zeroes all state and sets halted.
